alu_issue_queue: RTL and testbench

//  Out-of-order issue queue (reservation station) for the single ALU in SIDE MIPS.

---
 rtl/side_defs.sv | 44 ++++
 rtl/iq_select.sv | 25 ++
 rtl/alu_issue_queue.sv | 151 +++++++++++++++
 tb/tb_alu_issue_queue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/side_defs.sv
// Shared SIDE MIPS definitions for the ALU issue queue: field widths, the entry record
// and the operand wakeup helper used by both dispatch bypass and stored entries.
package side_defs;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned CW_W   = 4;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  tag1;
        logic              rdy1;
        logic [DATA_W-1:0] val1;
        logic [TAG_W-1:0]  tag2;
        logic              rdy2;
        logic [DATA_W-1:0] val2;
        logic [TAG_W-1:0]  phydst;
        logic [CW_W-1:0]   cw;
    } iq_entry_t;

    // Captures a broadcast result into any still-waiting source of a valid entry.
    function automatic iq_entry_t iq_wakeup(input iq_entry_t         e,
                                            input logic              wb_valid,
                                            input logic [TAG_W-1:0]  wb_tag,
                                            input logic [DATA_W-1:0] wb_data);
        iq_entry_t r;
        r = e;
        if (e.valid && wb_valid) begin
            if (!e.rdy1 && (e.tag1 == wb_tag)) begin
                r.rdy1 = 1'b1;
                r.val1 = wb_data;
            end
            if (!e.rdy2 && (e.tag2 == wb_tag)) begin
                r.rdy2 = 1'b1;
                r.val2 = wb_data;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_select.sv
// Oldest-first priority picker: slot 0 is the oldest, so the lowest set request bit wins.
module iq_select #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    assign any_o   = |req_i;
    // Isolate the lowest set bit.
    assign grant_o = req_i & (~req_i + DEPTH'(1));

    always_comb begin
        idx_o = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered reservation station for the single SIDE MIPS ALU: captures WB results,
// issues the oldest fully-ready entry each cycle and compacts the array on issue.
module alu_issue_queue
    import side_defs::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       DP_valid,
    output logic                       DP_ready,
    input  logic [OP_W-1:0]            DP_Operation,
    input  logic [DATA_W-1:0]          DP_imm,
    input  logic [TAG_W-1:0]           DP_Src1_tag,
    input  logic                       DP_Src1_rdy,
    input  logic [DATA_W-1:0]          DP_Src1,
    input  logic [TAG_W-1:0]           DP_Src2_tag,
    input  logic                       DP_Src2_rdy,
    input  logic [DATA_W-1:0]          DP_Src2,
    input  logic [TAG_W-1:0]           DP_Phydst,
    input  logic [CW_W-1:0]            DP_Commit_Window,
    input  logic                       WB_valid,
    input  logic [TAG_W-1:0]           WB_Phydst,
    input  logic [DATA_W-1:0]          WB_Result,
    output logic                       EX_en,
    output logic [OP_W-1:0]            EX_Operation,
    output logic [DATA_W-1:0]          EX_imm,
    output logic [DATA_W-1:0]          EX_Src1,
    output logic [DATA_W-1:0]          EX_Src2,
    output logic [TAG_W-1:0]           EX_Phydst,
    output logic [CW_W-1:0]            EX_Commit_Window,
    output logic [$clog2(DEPTH+1)-1:0] IQ_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    iq_entry_t        entry_q [DEPTH];
    iq_entry_t        new_entry;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] ins_slot;
    logic [DEPTH-1:0] req;
    logic [DEPTH-1:0] grant;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic             accept;

    assign DP_ready = (count_q < CNT_W'(DEPTH));
    assign accept   = DP_valid && DP_ready;
    // With a simultaneous issue everything above the issued slot slides down one place.
    assign ins_slot = count_q - CNT_W'(sel_any);

    always_comb begin
        new_entry        = '0;
        new_entry.valid  = 1'b1;
        new_entry.op     = DP_Operation;
        new_entry.imm    = DP_imm;
        new_entry.tag1   = DP_Src1_tag;
        new_entry.rdy1   = DP_Src1_rdy;
        new_entry.val1   = DP_Src1;
        new_entry.tag2   = DP_Src2_tag;
        new_entry.rdy2   = DP_Src2_rdy;
        new_entry.val2   = DP_Src2;
        new_entry.phydst = DP_Phydst;
        new_entry.cw     = DP_Commit_Window;
        new_entry        = iq_wakeup(new_entry, WB_valid, WB_Phydst, WB_Result);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        iq_entry_t slot_q, slot_d;
        iq_entry_t above, held;

        if (g == DEPTH - 1) begin : g_top
            assign above = '0;
        end else begin : g_mid
            assign above = entry_q[g+1];
        end

        always_comb begin
            held   = (sel_any && (IDX_W'(g) >= sel_idx)) ? above : slot_q;
            slot_d = iq_wakeup(held, WB_valid, WB_Phydst, WB_Result);
            if (accept && (ins_slot == CNT_W'(g))) begin
                slot_d = new_entry;
            end
            if (flush) begin
                slot_d.valid = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign entry_q[g] = slot_q;
        assign req[g]     = slot_q.valid & slot_q.rdy1 & slot_q.rdy2;
    end

    iq_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .req_i   (req),
        .grant_o (grant),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(accept) - CNT_W'(sel_any);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        EX_Operation     = '0;
        EX_imm           = '0;
        EX_Src1          = '0;
        EX_Src2          = '0;
        EX_Phydst        = '0;
        EX_Commit_Window = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                EX_Operation     = entry_q[i].op;
                EX_imm           = entry_q[i].imm;
                EX_Src1          = entry_q[i].val1;
                EX_Src2          = entry_q[i].val2;
                EX_Phydst        = entry_q[i].phydst;
                EX_Commit_Window = entry_q[i].cw;
            end
        end
    end

    assign EX_en    = sel_any;
    assign IQ_count = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: expected issues are queued at stimulus time and
// compared in order whenever the queue drives EX_en.
module tb_alu_issue_queue;
    import side_defs::*;

    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              DP_valid;
    logic              DP_ready;
    logic [OP_W-1:0]   DP_Operation;
    logic [DATA_W-1:0] DP_imm;
    logic [TAG_W-1:0]  DP_Src1_tag;
    logic              DP_Src1_rdy;
    logic [DATA_W-1:0] DP_Src1;
    logic [TAG_W-1:0]  DP_Src2_tag;
    logic              DP_Src2_rdy;
    logic [DATA_W-1:0] DP_Src2;
    logic [TAG_W-1:0]  DP_Phydst;
    logic [CW_W-1:0]   DP_Commit_Window;
    logic              WB_valid;
    logic [TAG_W-1:0]  WB_Phydst;
    logic [DATA_W-1:0] WB_Result;
    logic              EX_en;
    logic [OP_W-1:0]   EX_Operation;
    logic [DATA_W-1:0] EX_imm;
    logic [DATA_W-1:0] EX_Src1;
    logic [DATA_W-1:0] EX_Src2;
    logic [TAG_W-1:0]  EX_Phydst;
    logic [CW_W-1:0]   EX_Commit_Window;
    logic [2:0]        IQ_count;

    alu_issue_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .DP_valid         (DP_valid),
        .DP_ready         (DP_ready),
        .DP_Operation     (DP_Operation),
        .DP_imm           (DP_imm),
        .DP_Src1_tag      (DP_Src1_tag),
        .DP_Src1_rdy      (DP_Src1_rdy),
        .DP_Src1          (DP_Src1),
        .DP_Src2_tag      (DP_Src2_tag),
        .DP_Src2_rdy      (DP_Src2_rdy),
        .DP_Src2          (DP_Src2),
        .DP_Phydst        (DP_Phydst),
        .DP_Commit_Window (DP_Commit_Window),
        .WB_valid         (WB_valid),
        .WB_Phydst        (WB_Phydst),
        .WB_Result        (WB_Result),
        .EX_en            (EX_en),
        .EX_Operation     (EX_Operation),
        .EX_imm           (EX_imm),
        .EX_Src1          (EX_Src1),
        .EX_Src2          (EX_Src2),
        .EX_Phydst        (EX_Phydst),
        .EX_Commit_Window (EX_Commit_Window),
        .IQ_count         (IQ_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
        logic [TAG_W-1:0]  pd;
        logic [CW_W-1:0]   cw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush    = 1'b0;
        DP_valid = 1'b0;
        WB_valid = 1'b0;
    endtask

    task automatic dp(input logic [5:0] op, input logic [31:0] imm,
                      input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                      input logic [5:0] t2, input logic r2, input logic [31:0] v2,
                      input logic [5:0] pd, input logic [3:0] cw);
        DP_valid         = 1'b1;
        DP_Operation     = op;
        DP_imm           = imm;
        DP_Src1_tag      = t1;
        DP_Src1_rdy      = r1;
        DP_Src1          = v1;
        DP_Src2_tag      = t2;
        DP_Src2_rdy      = r2;
        DP_Src2          = v2;
        DP_Phydst        = pd;
        DP_Commit_Window = cw;
    endtask

    task automatic wb(input logic [5:0] tag, input logic [31:0] val);
        WB_valid  = 1'b1;
        WB_Phydst = tag;
        WB_Result = val;
    endtask

    task automatic push(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [5:0] pd, input logic [3:0] cw);
        exp_t e;
        e.op = op; e.imm = imm; e.s1 = s1; e.s2 = s2; e.pd = pd; e.cw = cw;
        sb.push_back(e);
    endtask

    task automatic check_issue();
        exp_t e;
        if (EX_en === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_issue observed=%0h expected=none", EX_Phydst);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ex_op", EX_Operation, e.op);
                chk("ex_imm", EX_imm, e.imm);
                chk("ex_src1", EX_Src1, e.s1);
                chk("ex_src2", EX_Src2, e.s2);
                chk("ex_phydst", EX_Phydst, e.pd);
                chk("ex_cw", EX_Commit_Window, e.cw);
            end
        end
    endtask

    // Inputs for this cycle are already driven; outputs reflect the current state.
    task automatic cycle();
        check_issue();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        dp(6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 4'd0);
        DP_valid  = 1'b0;
        WB_Phydst = '0;
        WB_Result = '0;
        rst       = 1'b1;
        #1;
        chk("rst_ex_en", EX_en, 1'b0);
        chk("rst_dp_ready", DP_ready, 1'b1);
        chk("rst_count", IQ_count, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ready dispatch
        dp(6'h01, 32'h100, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 6'd12, 4'd3);
        push(6'h01, 32'h100, 32'd5, 32'd7, 6'd12, 4'd3);
        cycle();
        idle();
        chk("t1_count1", IQ_count, 3'd1);
        chk("t1_ex_en", EX_en, 1'b1);
        cycle();
        chk("t1_count0", IQ_count, 3'd0);
        chk("t1_idle_src1", EX_Src1, 32'd0);

        // Wakeup
        dp(6'h02, 32'h200, 6'd9, 1'b0, 32'hBAD, 6'd3, 1'b1, 32'h33, 6'd13, 4'd4);
        push(6'h02, 32'h200, 32'hDEAD, 32'h33, 6'd13, 4'd4);
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            chk("t2_wait", EX_en, 1'b0);
            cycle();
        end
        wb(6'd9, 32'hDEAD);
        chk("t2_no_same_cycle", EX_en, 1'b0);
        cycle();
        idle();
        chk("t2_woken", EX_en, 1'b1);
        cycle();
        chk("t2_count0", IQ_count, 3'd0);

        // Age order
        dp(6'h03, 32'h300, 6'd4, 1'b0, 32'hBAD, 6'd5, 1'b1, 32'h22, 6'd20, 4'd5);
        cycle();
        dp(6'h04, 32'h400, 6'd6, 1'b1, 32'hB1, 6'd7, 1'b1, 32'hB2, 6'd21, 4'd6);
        push(6'h04, 32'h400, 32'hB1, 32'hB2, 6'd21, 4'd6);
        cycle();
        dp(6'h05, 32'h500, 6'd6, 1'b1, 32'hC1, 6'd7, 1'b1, 32'hC2, 6'd22, 4'd7);
        push(6'h05, 32'h500, 32'hC1, 32'hC2, 6'd22, 4'd7);
        cycle();
        idle();
        cycle();
        chk("t3_count_a", IQ_count, 3'd1);
        dp(6'h06, 32'h600, 6'd6, 1'b1, 32'hD1, 6'd7, 1'b1, 32'hD2, 6'd23, 4'd8);
        wb(6'd4, 32'h44);
        push(6'h03, 32'h300, 32'h44, 32'h22, 6'd20, 4'd5);
        push(6'h06, 32'h600, 32'hD1, 32'hD2, 6'd23, 4'd8);
        cycle();
        idle();
        chk("t3_a_first", EX_Phydst, 6'd20);
        cycle();
        cycle();
        chk("t3_count0", IQ_count, 3'd0);

        // Full
        for (int k = 0; k < 4; k++) begin
            dp(6'h07, 32'(k), 6'(30 + k), 1'b0, 32'hBAD, 6'd1, 1'b1, 32'(k), 6'(24 + k), 4'(k));
            cycle();
        end
        idle();
        chk("t4_full_ready", DP_ready, 1'b0);
        chk("t4_full_count", IQ_count, 3'd4);
        dp(6'h08, 32'h800, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1, 6'd40, 4'd0);
        cycle();
        idle();
        chk("t4_refused", IQ_count, 3'd4);
        chk("t4_no_issue", EX_en, 1'b0);
        wb(6'd31, 32'h31);
        push(6'h07, 32'd1, 32'h31, 32'd1, 6'd25, 4'd1);
        cycle();
        idle();
        dp(6'h09, 32'h900, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1, 6'd41, 4'd0);
        chk("t4_ready_during_issue", DP_ready, 1'b0);
        cycle();
        idle();
        chk("t4_count3", IQ_count, 3'd3);
        chk("t4_ready_again", DP_ready, 1'b1);
        wb(6'd30, 32'h30);
        push(6'h07, 32'd0, 32'h30, 32'd0, 6'd24, 4'd0);
        cycle();
        wb(6'd32, 32'h32);
        push(6'h07, 32'd2, 32'h32, 32'd2, 6'd26, 4'd2);
        cycle();
        wb(6'd33, 32'h33);
        push(6'h07, 32'd3, 32'h33, 32'd3, 6'd27, 4'd3);
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
        end
        chk("t4_drained", IQ_count, 3'd0);

        // Dispatch bypass
        dp(6'h0A, 32'hA00, 6'd2, 1'b1, 32'd1, 6'd20, 1'b0, 32'hBAD, 6'd30, 4'd9);
        wb(6'd20, 32'd77);
        push(6'h0A, 32'hA00, 32'd1, 32'd77, 6'd30, 4'd9);
        cycle();
        idle();
        chk("t5_bypass_en", EX_en, 1'b1);
        cycle();
        chk("t5_count0", IQ_count, 3'd0);

        // Flush
        for (int k = 0; k < 3; k++) begin
            dp(6'h0B, 32'(k), 6'(40 + k), 1'b0, 32'hBAD, 6'd1, 1'b1, 32'd0, 6'(32 + k), 4'(k));
            cycle();
        end
        idle();
        chk("t6_count3", IQ_count, 3'd3);
        flush = 1'b1;
        dp(6'h0C, 32'hC00, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1, 6'd45, 4'd0);
        cycle();
        idle();
        chk("t6_flush_count", IQ_count, 3'd0);
        chk("t6_flush_en", EX_en, 1'b0);
        wb(6'd40, 32'h1);
        cycle();
        idle();
        chk("t6_no_ghost", EX_en, 1'b0);
        cycle();

        // Async reset mid-cycle
        dp(6'h0D, 32'hD00, 6'd50, 1'b0, 32'hBAD, 6'd1, 1'b1, 32'h66, 6'd46, 4'd10);
        cycle();
        dp(6'h0E, 32'hE00, 6'd51, 1'b0, 32'hBAD, 6'd1, 1'b1, 32'h67, 6'd47, 4'd11);
        wb(6'd50, 32'h55);
        cycle();
        idle();
        chk("t6_pre_rst_en", EX_en, 1'b1);
        chk("t6_pre_rst_src1", EX_Src1, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_en", EX_en, 1'b0);
        chk("t6_rst_src1", EX_Src1, 32'd0);
        chk("t6_rst_phydst", EX_Phydst, 6'd0);
        chk("t6_rst_count", IQ_count, 3'd0);
        chk("t6_rst_ready", DP_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_post_rst_count", IQ_count, 3'd0);
        chk("t6_post_rst_en", EX_en, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
